// File: rtl/cmp_unit_pkg.sv
// Shared ALU constants for the compare unit.
//
// Holds the datapath width, the bit positions of the {N,Z,C,V} status
// flags, the flag vector type and a helper that assembles a flag vector
// from individual flag bits so every user agrees on the bit order.
package cmp_unit_pkg;

    // Operand width of the compare datapath.
    localparam int unsigned DataWidth = 32;

    // Status flag vector layout: bit3=N, bit2=Z, bit1=C, bit0=V.
    localparam int unsigned NumFlags = 4;
    localparam int unsigned FlagN    = 3;
    localparam int unsigned FlagZ    = 2;
    localparam int unsigned FlagC    = 1;
    localparam int unsigned FlagV    = 0;

    typedef logic [DataWidth-1:0] data_t;
    typedef logic [NumFlags-1:0]  flags_t;

    // Flag value loaded on reset.
    localparam flags_t FlagsReset = '0;

    // Assemble a flag vector using the package bit indices.
    function automatic flags_t pack_flags(input logic n, input logic z,
                                          input logic c, input logic v);
        flags_t f;
        f        = '0;
        f[FlagN] = n;
        f[FlagZ] = z;
        f[FlagC] = c;
        f[FlagV] = v;
        return f;
    endfunction

endpackage

// File: rtl/cmp_sub33.sv
// 33-bit subtract and status flag derivation, purely combinational.
//
// Ports:
//   a_i     : minuend (signed interpretation for N/V, unsigned for C)
//   b_i     : subtrahend
//   flags_o : {N,Z,C,V} of a_i - b_i
module cmp_sub33
    import cmp_unit_pkg::*;
(
    input  logic [DataWidth-1:0] a_i,
    input  logic [DataWidth-1:0] b_i,
    output logic [NumFlags-1:0]  flags_o
);

    // One extra bit captures the carry out of the two's-complement add.
    logic [DataWidth:0]   diff;
    logic [DataWidth-1:0] result;
    logic                 flag_n;
    logic                 flag_z;
    logic                 flag_c;
    logic                 flag_v;

    always_comb begin
        // a + ~b + 1 with carry out; carry set means no borrow (a >= b unsigned).
        diff   = {1'b0, a_i} + {1'b0, ~b_i} + {{DataWidth{1'b0}}, 1'b1};
        result = diff[DataWidth-1:0];

        flag_n = result[DataWidth-1];
        flag_z = (result == '0);
        flag_c = diff[DataWidth];
        // Overflow only possible when operand signs differ; then it shows
        // as the result sign disagreeing with the minuend sign.
        flag_v = (a_i[DataWidth-1] != b_i[DataWidth-1]) &&
                 (result[DataWidth-1] != a_i[DataWidth-1]);

        flags_o = pack_flags(flag_n, flag_z, flag_c, flag_v);
    end

endmodule

// File: rtl/cmp_unit.sv
// Compare unit: registered {N,Z,C,V} status flags from In1 - In2.
//
// Ports:
//   clk      : rising-edge clock
//   reset    : synchronous active-high reset, clears New_Flag
//   In1      : signed minuend
//   In2      : signed subtrahend
//   Flag     : current flags {N,Z,C,V}, passed through when S=0
//   S        : 1 = load flags from the compare, 0 = load Flag
//   New_Flag : registered flags, one cycle after sampling
module cmp_unit
    import cmp_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DataWidth-1:0] In1,
    input  logic [DataWidth-1:0] In2,
    input  logic [NumFlags-1:0]  Flag,
    input  logic                 S,
    output logic [NumFlags-1:0]  New_Flag
);

    flags_t cmp_flags;
    flags_t flags_d;
    flags_t flags_q;

    cmp_sub33 u_sub33 (
        .a_i     (In1),
        .b_i     (In2),
        .flags_o (cmp_flags)
    );

    always_comb begin
        flags_d = S ? cmp_flags : Flag;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= FlagsReset;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign New_Flag = flags_q;

endmodule

// File: tb/tb_cmp_unit.sv
module tb_cmp_unit;

    logic        clk;
    logic        reset;
    logic [31:0] In1;
    logic [31:0] In2;
    logic [3:0]  Flag;
    logic        S;
    logic [3:0]  New_Flag;

    int unsigned n_checks;
    int unsigned n_fail;

    logic [3:0]  exp_q[$];
    string       tag_q[$];

    cmp_unit dut (
        .clk      (clk),
        .reset    (reset),
        .In1      (In1),
        .In2      (In2),
        .Flag     (Flag),
        .S        (S),
        .New_Flag (New_Flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: flags from arithmetic comparisons on wide integers.
    function automatic logic [3:0] model(input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, sd;
        logic [31:0] d;
        logic n, z, c, v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sd = sa - sb;
        d  = a - b;
        n  = d[31];
        z  = (a == b);
        c  = ({32'd0, a} >= {32'd0, b});
        v  = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
        return {n, z, c, v};
    endfunction

    // Drive one cycle of stimulus, push the expectation, then check it 1ns
    // after the sampling edge.
    task automatic step(input string tag, input logic rst, input logic s,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] f, input logic [3:0] exp);
        logic [3:0] e;
        string      t;
        reset = rst;
        S     = s;
        In1   = a;
        In2   = b;
        Flag  = f;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: observed %b required scoreboard entry", tag, New_Flag);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (New_Flag === e) else begin
                n_fail++;
                $error("FAIL %s: observed %b expected %b", t, New_Flag, e);
            end
        end
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [3:0]  rf;
        logic        rs;
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1; S = 1'b0; In1 = '0; In2 = '0; Flag = '0;
        @(posedge clk);
        #1;

        step("reset",        1'b1, 1'b1, 32'd5,        32'd5,        4'b1111, 4'b0000);
        step("2_minus_3",    1'b0, 1'b1, 32'd2,        32'd3,        4'b0000, 4'b1000);
        step("1_minus_m3",   1'b0, 1'b1, 32'd1,        -32'sd3,      4'b1111, 4'b0000);
        step("m6_minus_m2",  1'b0, 1'b1, -32'sd6,      -32'sd2,      4'b0000, 4'b1000);
        step("4_minus_m4",   1'b0, 1'b1, 32'd4,        -32'sd4,      4'b0000, 4'b0000);
        step("ffff_minus_9", 1'b0, 1'b1, 32'hFFFFFFFF, 32'd9,        4'b0000, 4'b1010);
        step("equal_10",     1'b0, 1'b1, 32'd10,       32'd10,       4'b0000, 4'b0110);
        step("max_minus_m1", 1'b0, 1'b1, 32'h7FFFFFFF, 32'hFFFFFFFF, 4'b0000, 4'b1001);
        step("min_minus_1",  1'b0, 1'b1, 32'h80000000, 32'd1,        4'b0000, 4'b0011);
        step("zero_minus_min", 1'b0, 1'b1, 32'd0,      32'h80000000, 4'b0000, 4'b1001);
        step("pos_minus_min",  1'b0, 1'b1, 32'd7,      32'h80000000, 4'b0000, 4'b1001);
        step("in2_zero",     1'b0, 1'b1, 32'd5,        32'd0,        4'b0000, 4'b0010);
        step("equal_neg",    1'b0, 1'b1, 32'h80000000, 32'h80000000, 4'b1111, 4'b0110);
        step("pass_0101",    1'b0, 1'b0, 32'd2,        32'd3,        4'b0101, 4'b0101);
        step("pass_1010",    1'b0, 1'b0, 32'd10,       32'd10,       4'b1010, 4'b1010);
        step("mid_reset",    1'b1, 1'b1, 32'd12,       32'd12,       4'b1111, 4'b0000);
        step("post_reset",   1'b0, 1'b1, 32'd2,        32'd3,        4'b0000, 4'b1000);
        step("post_reset_eq", 1'b0, 1'b1, 32'd77,      32'd77,       4'b0000, 4'b0110);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom();
            rb = (i % 5 == 0) ? ra : $urandom();
            rf = 4'($urandom_range(0, 15));
            rs = 1'($urandom_range(0, 3) != 0);
            step("random", 1'b0, rs, ra, rb, rf, rs ? model(ra, rb) : rf);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cmp_unit.md
CMP_UNIT -- requirements
Module: cmp_unit

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 In1  input  32  signed minuend.
REQ-005 In2  input  32  signed subtrahend.
REQ-006 Flag  input  4  current status flags {N,Z,C,V}: bit3=N, bit2=Z, bit1=C, bit0=V.
REQ-007 S  input  1  set-flags enable; 1 = update flags from the compare, 0 = pass Flag through.
REQ-008 New_Flag  output  4  registered flags {N,Z,C,V}, same bit order as Flag.
REQ-009 Port order SHALL be clk, reset, In1, In2, Flag, S, New_Flag.

Function
REQ-010 The block SHALL compute diff = In1 + ~In2 + 1 as a 33-bit unsigned sum; the compare result is diff[31:0], and the block has no result output.
REQ-011 N SHALL equal diff[31].
REQ-012 Z SHALL be 1 iff diff[31:0] == 0.
REQ-013 C SHALL equal diff[32] (carry, no-borrow convention): 1 iff unsigned In1 >= unsigned In2.
REQ-014 V SHALL be 1 iff In1[31] != In2[31] and diff[31] != In1[31].
REQ-015 On each rising clk edge with reset=0 and S=1, New_Flag SHALL load {N,Z,C,V} computed from the current In1/In2.
REQ-016 On each rising clk edge with reset=0 and S=0, New_Flag SHALL load Flag unchanged.
REQ-017 Latency SHALL be exactly 1 cycle from input sampling to New_Flag; there is no handshake, and every cycle is independent.
REQ-018 Boundaries:
- In1 == In2 SHALL give Z=1, C=1, N=0, V=0.
- In2 = 0x80000000 with In1 >= 0 SHALL produce V=1.
- In2 = 0 SHALL give C=1.
REQ-019 X/Z-free inputs SHALL produce X-free New_Flag; the block SHALL have no combinational path from inputs to New_Flag.

Reset
REQ-020 When reset=1 at a rising clk edge, New_Flag SHALL become 4'b0000, regardless of S, Flag, In1 or In2.
REQ-021 A reset asserted mid-stream SHALL discard the pending compare; the first post-reset cycle with reset=0 SHALL behave per REQ-015/016.

Structure
REQ-022 Flag bit indices (N=3, Z=2, C=1, V=0) and data width (32) SHALL be constants in the shared ALU package.
REQ-023 One sub-module, cmp_sub33, SHALL implement the 33-bit subtract and flag derivation combinationally; cmp_unit SHALL hold the flag register and the S mux.

Verification
REQ-024 In1=2, In2=3, S=1 -> New_Flag=1000 one cycle later.
REQ-025 Sign cases, S=1:
- In1=1, In2=-3 -> 0000.
- In1=-6, In2=-2 -> 1000.
- In1=4, In2=-4 -> 0000.
REQ-026 Unsigned and equal cases, S=1:
- In1=0xFFFFFFFF, In2=9 -> 1010.
- In1=10, In2=10 -> 0110.
REQ-027 In1=0x7FFFFFFF, In2=-1, S=1 -> 1001; In1=0x80000000, In2=1, S=1 -> 0011.
REQ-028 S=0, Flag=0101, any In1/In2 -> New_Flag=0101 next cycle.
REQ-029 reset=1 while S=1 with In1=In2 -> New_Flag=0000; after deassertion, the next compare updates normally.
